circuit_sequencer: RTL

Stimulus-and-capture controller for the lab's two-flip-flop sequential circuit (inputs A,B,C,D,CLK; outputs Y,Z).
- On START it walks all 16 ABCD combinations in ascending order.
- For each vector it drives the inputs, waits for gate settling, and issues one DUT clock pulse.
- After a hold interval it samples Y/Z into a 32-bit result word.
- It sits between the lab top-level (switches/LEDs or bench) and the circuit instance, and sequences it without manual clocking.

---
 rtl/circuit_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/circuit_sequencer.sv
// Walks all 16 ABCD vectors into the lab flip-flop circuit, pulses its clock
// once per vector and packs the sampled Y/Z pairs into RESULT.
module circuit_sequencer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic        Y_IN,
  input  logic        Z_IN,
  output logic [3:0]  VEC,
  output logic        DUT_CLK,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [4:0]  Z_COUNT
);

  // state  | meaning
  // IDLE   | outputs parked, waiting for START
  // SETUP  | vector driven, gates settling
  // PULSE  | DUT_CLK high for one cycle
  // HOLD   | waiting for the flip-flop outputs to settle
  // SAMPLE | Y/Z captured on the exit edge
  // DONE   | one-cycle completion strobe
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_SAMPLE, S_DONE
  } state_t;

  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  zcount_q, zcount_d;
  logic [3:0]  vec_q, vec_d;
  logic        dut_clk_q, dut_clk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zcount_d = zcount_q;

    unique case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          state_d  = S_SETUP;
          idx_d    = 4'd0;
          cnt_d    = SETUP_LOAD;
          result_d = 32'd0;
          zcount_d = 5'd0;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PULSE: begin
        state_d = S_HOLD;
        cnt_d   = HOLD_LOAD;
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SAMPLE: begin
        result_d[{idx_q, 1'b1}] = Y_IN;
        result_d[{idx_q, 1'b0}] = Z_IN;
        zcount_d = zcount_q + {4'd0, Z_IN};
        if (idx_q == 4'hF) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
          idx_d   = idx_q + 4'd1;
          cnt_d   = SETUP_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every transition, including a pending sample.
    if (ABORT && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      idx_d    = 4'd0;
      cnt_d    = 8'd0;
      result_d = result_q;
      zcount_d = zcount_q;
    end

    busy_d    = (state_d == S_SETUP) || (state_d == S_PULSE) ||
                (state_d == S_HOLD)  || (state_d == S_SAMPLE);
    vec_d     = busy_d ? idx_d : 4'd0;
    dut_clk_d = (state_d == S_PULSE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= 8'd0;
      result_q  <= 32'd0;
      zcount_q  <= 5'd0;
      vec_q     <= 4'd0;
      dut_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zcount_q  <= zcount_d;
      vec_q     <= vec_d;
      dut_clk_q <= dut_clk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign VEC     = vec_q;
  assign DUT_CLK = dut_clk_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RESULT  = result_q;
  assign Z_COUNT = zcount_q;

endmodule
